// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   GLYPH_TABLE    : 16 active-high glyphs {g,f,e,d,c,b,a}, nibble 0 in the LSBs
//   SEG_OFF        : all segments dark (active-high form)
//   MAX_DIGITS     : largest digit count the driver supports
//   seg7_apply_pol : converts one active-high signal to pin polarity
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n occupies bits [7*n +: 7]; listed from F down to 0.
    localparam logic [16*7-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic seg7_apply_pol(input logic active, input logic inv);
        return active ^ inv;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
// Combinational hexadecimal nibble to seven-segment glyph decoder.
//   i_nib : nibble to display (0..F)
//   o_seg : active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TABLE[7*int'(i_nib) +: 7];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed hexadecimal seven-segment driver for 1..8 digits. A value
// captured with load is held in a pending register and copied into a shadow
// register only at frame boundaries, so a frame never mixes old and new data.
// Each digit slot lasts SCAN_DIV cycles: one blank cycle for ghost
// suppression followed by SCAN_DIV-1 cycles showing the digit.
//
// Parameters:
//   DIGITS       : number of digits scanned (1..8)
//   SCAN_DIV     : clock cycles per digit slot (>= 2)
//   COMMON_ANODE : 1 = seg_out/dp_out/dig_sel active-low, 0 = active-high
//
// Ports:
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   ena         : scan enable; low freezes counters and blanks outputs
//   load        : capture strobe for value/dp_in
//   value       : packed nibbles, digit 0 in bits [3:0]
//   dp_in       : decimal-point request per digit
//   seg_out     : registered segments {g,f,e,d,c,b,a}
//   dp_out      : registered decimal point
//   dig_sel     : registered one-hot digit enable
//   frame_start : one-cycle pulse while the digit 0 blank is on the outputs
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN : when defined, digits above the most
//   significant non-zero nibble have their segments dark (digit 0 is always
//   shown). Undefined: every digit shows its glyph.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [6:0]          seg_out,
    output logic                dp_out,
    output logic [DIGITS-1:0]   dig_sel,
    output logic                frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Pin levels of a dark / deselected output for the chosen polarity.
    localparam logic [6:0]        SEG_IDLE = {7{COMMON_ANODE}};
    localparam logic [DIGITS-1:0] DIG_IDLE = {DIGITS{COMMON_ANODE}};

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [4*DIGITS-1:0] r_shad_val;
    logic [DIGITS-1:0]   r_shad_dp;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_fs;

    logic                w_presc_last;
    logic                w_boundary;
    logic                w_show;
    logic                w_lz_blank;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_glyph;
    logic [6:0]          w_seg_hi;
    logic [DIGITS-1:0]   w_dig_hi;
    logic                w_dp_hi;
    logic [6:0]          w_seg_pin;
    logic [DIGITS-1:0]   w_dig_pin;
    logic                w_dp_pin;

    assign w_presc_last = (r_presc == PRESC_LAST);
    assign w_boundary   = ena && w_presc_last && (r_idx == IDX_LAST);

    // Nibble, decimal point and digit enable for the digit being scanned.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_onehot = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == IW'(d)) begin
                w_nib       = r_shad_val[4*d +: 4];
                w_dp_sel    = r_shad_dp[d];
                w_onehot[d] = 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] w_msnz;

    // Highest digit holding a non-zero nibble; stays 0 for an all-zero value
    // so digit 0 is never blanked.
    always_comb begin
        w_msnz = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_shad_val[4*d +: 4] != 4'h0) begin
                w_msnz = IW'(d);
            end
        end
    end

    assign w_lz_blank = (r_idx > w_msnz);
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_glyph u_glyph (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    // Slot cycle 0 is the ghost-suppression blank.
    assign w_show   = ena && (r_presc != '0);
    assign w_seg_hi = (w_show && !w_lz_blank) ? w_glyph : SEG_OFF;
    assign w_dig_hi = w_show ? w_onehot : '0;
    assign w_dp_hi  = w_show && w_dp_sel;

    always_comb begin
        w_seg_pin = '0;
        w_dig_pin = '0;
        for (int b = 0; b < 7; b++) begin
            w_seg_pin[b] = seg7_apply_pol(w_seg_hi[b], COMMON_ANODE);
        end
        for (int b = 0; b < DIGITS; b++) begin
            w_dig_pin[b] = seg7_apply_pol(w_dig_hi[b], COMMON_ANODE);
        end
        w_dp_pin = seg7_apply_pol(w_dp_hi, COMMON_ANODE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (ena) begin
            if (w_presc_last) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // A load landing on the boundary edge goes straight to the shadow so it
    // is shown in the very next frame rather than one frame later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_shad_val <= '0;
            r_shad_dp  <= '0;
        end else begin
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
            end
            if (w_boundary) begin
                r_shad_val <= load ? value : r_pend_val;
                r_shad_dp  <= load ? dp_in : r_pend_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= SEG_IDLE;
            r_dp  <= COMMON_ANODE;
            r_dig <= DIG_IDLE;
            r_fs  <= 1'b0;
        end else begin
            r_seg <= w_seg_pin;
            r_dp  <= w_dp_pin;
            r_dig <= w_dig_pin;
            r_fs  <= ena && (r_presc == '0) && (r_idx == '0);
        end
    end

    assign seg_out     = r_seg;
    assign dp_out      = r_dp;
    assign dig_sel     = r_dig;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4. Two instances
// share all inputs: u_dut (COMMON_ANODE=0) and u_ca (COMMON_ANODE=1).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;
    logic        fs;
    logic [6:0]  seg_ca;
    logic        dp_ca;
    logic [3:0]  dig_ca;
    logic        fs_ca;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .COMMON_ANODE (1'b0)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .seg_out     (seg),
        .dp_out      (dp),
        .dig_sel     (dig),
        .frame_start (fs)
    );

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .COMMON_ANODE (1'b1)
    ) u_ca (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .seg_out     (seg_ca),
        .dp_out      (dp_ca),
        .dig_sel     (dig_ca),
        .frame_start (fs_ca)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (fs === 1'b1) break;
            @(negedge clk);
        end
        check({tag, " frame_start"}, 32'(fs), 32'd1);
    endtask

    // Checks one whole 16-cycle frame starting at the negedge where
    // frame_start is visible. segs packs the expected glyph of digit d at
    // [7*d +: 7]. A load pulse of inj_val is driven after sampling cycle inj_k.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] dps, input int inj_k,
                               input logic [15:0] inj_val);
        for (int k = 0; k < 16; k++) begin
            int d;
            int s;
            string t;
            d = k / 4;
            s = k % 4;
            t = $sformatf("%s k%0d", tag, k);
            check({t, " fs"}, 32'(fs), (k == 0) ? 32'd1 : 32'd0);
            if (s == 0) begin
                check({t, " seg"}, 32'(seg), 32'h00);
                check({t, " dig"}, 32'(dig), 32'h0);
                check({t, " dp"},  32'(dp),  32'h0);
            end else begin
                check({t, " seg"}, 32'(seg), 32'(segs[7*d +: 7]));
                check({t, " dig"}, 32'(dig), 32'(4'b0001 << d));
                check({t, " dp"},  32'(dp),  32'(dps[d]));
            end
            if (k == inj_k) begin
                load  = 1'b1;
                value = inj_val;
                dp_in = 4'b0000;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        load  = 1'b0;
        value = 16'h0000;
        dp_in = 4'b0000;

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        check("rst seg",    32'(seg),    32'h00);
        check("rst dp",     32'(dp),     32'h0);
        check("rst dig",    32'(dig),    32'h0);
        check("rst fs",     32'(fs),     32'h0);
        check("rst ca seg", 32'(seg_ca), 32'h7F);
        check("rst ca dig", 32'(dig_ca), 32'hF);
        check("rst ca dp",  32'(dp_ca),  32'h1);

        // Release with a load before the first boundary.
        rst_n = 1'b1;
        ena   = 1'b1;
        load  = 1'b1;
        value = 16'h12AF;
        dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        wait_fs("f1");

        // Frame 1 still shows the reset shadow of zero.
        check_frame("f1", {LZ, LZ, LZ, 7'h3F}, 4'b0000, -1, 16'h0000);
        // Frame 2 shows 12AF; a mid-frame load of 0000 must not disturb it.
        check_frame("f2", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100, 5, 16'h0000);
        // Frame 3 shows 0000; load 8888 on the boundary edge.
        check_frame("f3", {LZ, LZ, LZ, 7'h3F}, 4'b0000, 14, 16'h8888);
        // Frame 4 shows the bypassed 8888.
        check_frame("f4", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, -1, 16'h0000);

        // Frame 5: common-anode view of the 8 on digit 0.
        check("f5 fs", 32'(fs), 32'd1);
        @(negedge clk);
        check("ca8 seg", 32'(seg_ca), 32'h00);
        check("ca8 dig", 32'(dig_ca), 32'hE);
        check("ca8 dp",  32'(dp_ca),  32'h1);

        // Pause five cycles in the middle of digit 2's slot.
        repeat (8) @(negedge clk);
        check("pre-pause seg", 32'(seg), 32'h7F);
        check("pre-pause dig", 32'(dig), 32'h4);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("pause%0d seg", i), 32'(seg), 32'h00);
            check($sformatf("pause%0d dig", i), 32'(dig), 32'h0);
            check($sformatf("pause%0d dp", i),  32'(dp),  32'h0);
            check($sformatf("pause%0d fs", i),  32'(fs),  32'h0);
        end
        ena = 1'b1;
        @(negedge clk);
        check("resume0 seg", 32'(seg), 32'h7F);
        check("resume0 dig", 32'(dig), 32'h4);
        @(negedge clk);
        check("resume1 seg", 32'(seg), 32'h7F);
        check("resume1 dig", 32'(dig), 32'h4);
        @(negedge clk);
        check("resume2 seg", 32'(seg), 32'h00);
        check("resume2 dig", 32'(dig), 32'h0);
        @(negedge clk);
        check("resume3 seg", 32'(seg), 32'h7F);
        check("resume3 dig", 32'(dig), 32'h8);

        // Reset in the middle of digit 3's slot.
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst seg",    32'(seg),    32'h00);
        check("mrst dig",    32'(dig),    32'h0);
        check("mrst dp",     32'(dp),     32'h0);
        check("mrst fs",     32'(fs),     32'h0);
        check("mrst ca seg", 32'(seg_ca), 32'h7F);
        check("mrst ca dig", 32'(dig_ca), 32'hF);
        check("mrst ca dp",  32'(dp_ca),  32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post fs",  32'(fs),  32'h1);
        check("post dig", 32'(dig), 32'h0);
        @(negedge clk);
        check("post seg",    32'(seg),    32'h3F);
        check("post dig0",   32'(dig),    32'h1);
        check("post ca seg", 32'(seg_ca), 32'h40);
        check("post ca dig", 32'(dig_ca), 32'hE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed hexadecimal seven-segment display driver for up to eight digits. It captures a packed nibble vector, holds it in a frame-synchronous shadow register so the display never tears, and scans one digit at a time with a programmable dwell and a one-cycle ghost-suppression blank. It sits between the design's value-producing logic and the board's segment/digit-select pins, replacing single-digit combinational decoding.

## Interface
- DIGITS, 4: number of digits scanned, legal 1..8
- SCAN_DIV, 1000: clock cycles per digit slot, legal >= 2
- COMMON_ANODE, 0: 1 = segment and digit-select outputs active-low; 0 = active-high
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- ena  input  1  scan enable; low freezes counters and blanks outputs
- load  input  1  capture strobe for value/dp_in
- value  input  4*DIGITS  packed nibbles, digit 0 in bits [3:0]
- dp_in  input  DIGITS  decimal-point request per digit
- seg_out  output  7  segments {g,f,e,d,c,b,a}, registered
- dp_out  output  1  decimal point, registered
- dig_sel  output  DIGITS  one-hot digit enable, registered
- frame_start  output  1  one-cycle pulse when digit 0 slot begins

## Operation
- Registers: prescaler (0..SCAN_DIV-1), digit index (0..DIGITS-1), pending {value,dp}, shadow {value,dp}.
- ena=1: prescaler increments; at SCAN_DIV-1 wraps to 0 and index advances, DIGITS-1 wraps to 0.
- Frame boundary: ena=1, index=DIGITS-1, prescaler=SCAN_DIV-1. On that edge shadow <= pending.
- load=1: pending <= {value,dp_in}. If load coincides with a frame boundary, shadow <= {value,dp_in} directly (bypass); new data shows in the frame starting next cycle.
- Loads mid-frame never alter the frame in progress.
- Glyphs (active-high form): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 67, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Slot state prescaler=0: blank (segments, dp, dig_sel all inactive). Prescaler>=1: dig_sel bit index active, seg_out = glyph(shadow nibble[index]), dp_out = shadow dp[index].
- ena=0: counters, pending, shadow hold (load still captured into pending); outputs inactive.
- COMMON_ANODE=1 inverts seg_out, dp_out, dig_sel after all other logic.
- States: no explicit FSM beyond prescaler/index; BLANK (prescaler=0) and SHOW (else) per slot.

## Timing
- Outputs registered: output at cycle t+1 reflects counter/shadow state at cycle t; one-cycle latency.
- frame_start asserted in the cycle the outputs show the blank of digit 0 slot.
- Reset (rst_n=0 at edge): prescaler=0, index=0, pending=0, shadow=0, frame_start=0, seg_out/dp_out/dig_sel inactive (0 when COMMON_ANODE=0; all ones when 1). Reset mid-frame aborts the scan; first frame after release starts at digit 0.
- First frame after reset displays shadow=0; a load before the first boundary appears from frame 2.
- Counter widths: $clog2(SCAN_DIV) and max(1,$clog2(DIGITS)); no overflow beyond terminal counts.
- DIGITS=1: every slot is a frame boundary; frame_start pulses every SCAN_DIV cycles.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: digits above the most-significant non-zero nibble of shadow show segments off (dig_sel still active, dp_out still follows dp); digit 0 always shown, so all-zero displays a single 0.
- Undefined: every digit shows its glyph, including leading zeros.

## Structure
- seg7_pkg: glyph table constant, SEG_OFF constant, max DIGITS constant, polarity-apply function.
- Sub-module seg7_glyph: combinational nibble -> 7-bit active-high glyph; one instance on the selected nibble.

## Test plan
DIGITS=4, SCAN_DIV=4, COMMON_ANODE=0 unless stated.
- Reset held 3 cycles -> seg_out=00, dp_out=0, dig_sel=0000, frame_start=0.
- load value=16'h12AF, dp_in=4'b0100 before boundary -> next frame: digit0 71/0001, digit1 77/0010, digit2 5B/0100 with dp_out=1, digit3 06/1000; each slot 1 blank + 3 shown cycles.
- Mid-frame load 16'h0000 -> current frame stays 12AF; next frame 3F on all digits; with SEG7_LEADING_ZERO_BLANK_EN digits 1-3 segments 00, digit0 3F.
- load 16'h8888 on exact boundary cycle -> following frame shows 7F on every digit (bypass).
- ena low 5 cycles mid-slot of digit 2 -> outputs inactive next cycle; on resume digit 2 continues from held prescaler.
- COMMON_ANODE=1: reset -> seg_out=7F, dig_sel=F; displaying 8 on digit0 -> seg_out=00, dig_sel=1110; rst_n low mid-frame -> next cycle all inactive, index=0.
